// File: rtl/mul_seq.sv
// Iterative shift-add multiplier for the EX-stage MUL/MULH/MULHU path.
// Ports: mul_clk, resetn, mul/mul_signed/x/y request in, p/complete out.
module mul_seq #(
  parameter int XLEN = 32
) (
  input  logic              mul_clk,
  input  logic              resetn,
  input  logic              mul,
  input  logic              mul_signed,
  input  logic [XLEN-1:0]   x,
  input  logic [XLEN-1:0]   y,
  output logic [2*XLEN-1:0] p,
  output logic              complete
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              xs;
  logic              ys;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     count;

  logic              x_neg;
  logic              y_neg;
  logic [XLEN-1:0]   x_mag;
  logic [XLEN-1:0]   y_mag;
  logic              last_iter;
  logic              neg_res;

  // Magnitudes: -(-2^(XLEN-1)) wraps to 2^(XLEN-1), which is
  // exactly the unsigned magnitude wanted.
  assign x_neg     = x[XLEN-1] & mul_signed;
  assign y_neg     = y[XLEN-1] & mul_signed;
  assign x_mag     = x_neg ? -x : x;
  assign y_mag     = y_neg ? -y : y;
  assign last_iter = (count == CW'(XLEN - 1));
  assign neg_res   = xs ^ ys;

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE lasts two edges: the first raises complete,
  // the second (complete already high) returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (mul) state_nxt = BUSY;
      end
      BUSY: begin
        if (!mul)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        if (complete) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The multiplicand is kept pre-shifted in a 2*XLEN register,
  // so each step adds it directly instead of shifting by count.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      xs       <= 1'b0;
      ys       <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      p        <= '0;
      complete <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mul) begin
            xs     <= x_neg;
            ys     <= y_neg;
            mcand  <= {{XLEN{1'b0}}, x_mag};
            mplier <= y_mag;
            acc    <= '0;
            count  <= '0;
          end
        end
        BUSY: begin
          if (mul) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        DONE: begin
          if (!complete) begin
            p        <= neg_res ? -acc : acc;
            complete <= 1'b1;
          end else begin
            complete <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative shift-add multiplier; the responder for the EX-stage MUL/MULH/MULHU request path.
- Uses the same start/complete handshake as the divider: the requester raises mul and holds it and the operands until complete.
- Delivers a full 64-bit signed or unsigned product of two 32-bit operands in a fixed 33 cycles after acceptance.
- Sits beside div under the EX stage and shares its stall logic.

Parameters:
- XLEN, 32, operand width; product width is 2*XLEN. Iteration counter width is clog2(XLEN)+1.

Ports:
- mul_clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- mul  in  1  request; held high by requester until it samples complete=1.
- mul_signed  in  1  1: two's-complement operands; 0: unsigned.
- x  in  XLEN  multiplicand; sampled only on the accept edge.
- y  in  XLEN  multiplier; sampled only on the accept edge.
- p  out  2*XLEN  product; registered.
- complete  out  1  one-cycle pulse; p is valid while complete=1.

Behaviour:
- Reset (async, resetn=0): state=IDLE, count=0, p=0, complete=0, all internal operand/accumulator registers 0.
- States: IDLE, BUSY, DONE.
- IDLE with mul=1 (accept edge E0):
  - latch xs = x[XLEN-1]&mul_signed and ys = y[XLEN-1]&mul_signed;
  - latch |x| and |y| as XLEN-bit unsigned values; |-2^31| = 0x80000000, no overflow;
  - set acc=0, count=0, go to BUSY.
- IDLE with mul=0: hold; p keeps its last value.
- BUSY, each edge E1..E32:
  - if the multiplier LSB is 1, add the zero-extended multiplicand, shifted by count, into the 2*XLEN-bit acc;
  - shift the multiplier right by 1; count+1;
  - after the iteration with count=XLEN-1, go to DONE.
- DONE entry (edge E33): p = (xs^ys) ? -acc (64-bit two's complement) : acc; complete=1.
- Edge E34: complete=0, go to IDLE regardless of mul. No new request can be accepted before E35.
- Latency:
  - complete is high exactly in the cycle after E33, i.e. 33 edges after acceptance;
  - this is below the 34-clock requester time-out;
  - the throughput bound is one product per 35 edges when mul is reasserted immediately.
- Hold rule: p is stable from E33 until the DONE entry of the next operation. It does not change during IDLE or BUSY.
- Operand changes on x, y or mul_signed after E0 are ignored.
- Abort: mul=0 sampled in BUSY sends the FSM to IDLE at that edge.
  - complete is not asserted; p keeps its previous value.
- Simultaneous events:
  - mul=1 sampled while in DONE has no effect; the requester drops mul on that same edge.
  - mul=0 sampled in DONE has no effect; complete still deasserts at E34.
- Reset mid-operation: any state returns immediately to IDLE with complete=0 and p=0.
- Arithmetic: unsigned mode gives p = x*y exactly (no truncation). Signed mode gives the exact 64-bit two's-complement product.

Test Plan:
- Unsigned 0xFFFFFFFF * 0xFFFFFFFF -> complete 33 edges after accept; p=0xFFFFFFFE00000001; complete high exactly one cycle.
- Signed:
  - 0x80000000 * 0x80000000 -> p=0x4000000000000000;
  - 0xFFFFFFFD(-3) * 7 -> p=0xFFFFFFFFFFFFFFEB(-21);
  - -1 * -1 -> p=1.
- Unsigned 0x80000000 * 2 -> p=0x0000000100000000. Repeated with mul_signed=1 -> p=0xFFFFFFFF00000000.
- Abort and operand rules:
  - drop mul at E10 -> back in IDLE, complete never asserted, p unchanged;
  - change x/y at E5 of a normal operation -> result uses the E0 values.
- resetn=0 pulsed at E20 -> p=0 and complete=0 immediately (async). A new request after release completes correctly (5*6 -> p=30).
- Random regression: back-to-back requests with 0-3 idle cycles, random sign mode and operands. Check against the 64-bit reference product each time; no operation takes more than 33 edges to complete.
